// File: rtl/riscv_multi_cycle_processor.sv
// riscv_multi_cycle_processor
//   Multi-cycle RV32I-subset core with its own instruction and data memories.
//   Each instruction walks FETCH -> DECODE -> EXECUTE [-> MEM] [-> WRITEBACK].
//   The core stops in HALT on EBREAK or on any unsupported encoding. Only reset
//   leaves HALT.
//
//   Optional feature macro: RISCV_MUL_EN
//     defined   : MUL (funct7=0000001, funct3=000) is executed.
//     undefined : MUL is an illegal instruction.
//
//   Ports
//     clk         single clock, rising edge
//     rstn        asynchronous active-low reset. Clears the core state, the
//                 register file and the data memory. Instruction memory keeps
//                 its contents.
//     imem_we     instruction-memory write enable. Works in any state, even
//                 while rstn is low.
//     imem_addr   instruction word index for the write
//     imem_wdata  instruction word to write
//     x5, x6      live register contents
//     mem1        live contents of data-memory word 1
//     halted      core is stopped
//     illegal     the stop was caused by an unsupported encoding
//
//   Assumptions: REG_WIDTH >= 32, REG_COUNT <= 32, and NUM_MEM_LOCS and
//   NUM_INST are powers of two, so a modulo is a plain bit slice.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   FETCH     | IR <= imem[pc word]
//   DECODE    | read rs1/rs2 into A/B, form immediate, trap EBREAK/illegal
//   EXECUTE   | ALU op or effective address; branches resolve pc here
//   MEM       | SW writes data memory (pc += 4); LW latches MDR
//   WRITEBACK | rd <= result; pc <= pc + 4, or pc + J-imm for JAL
//   HALT      | frozen until reset
module riscv_multi_cycle_processor #(
   parameter int REG_WIDTH    = 32,
   parameter int REG_COUNT    = 32,
   parameter int NUM_MEM_LOCS = 64,
   parameter int NUM_INST     = 128
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        imem_we,
   input  logic [$clog2(NUM_INST)-1:0] imem_addr,
   input  logic [31:0]                 imem_wdata,
   output logic [REG_WIDTH-1:0]        x5,
   output logic [REG_WIDTH-1:0]        x6,
   output logic [REG_WIDTH-1:0]        mem1,
   output logic                        halted,
   output logic                        illegal
);

   localparam int IADDR_W = $clog2(NUM_INST);
   localparam int DADDR_W = $clog2(NUM_MEM_LOCS);
   localparam int RIDX_W  = $clog2(REG_COUNT);
   localparam int SH_W    = $clog2(REG_WIDTH);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXECUTE,
      MEM,
      WRITEBACK,
      HALT
   } state_t;

   state_t state, state_nxt;

   logic [31:0]          imem [NUM_INST];
   logic [REG_WIDTH-1:0] rf   [REG_COUNT];
   logic [REG_WIDTH-1:0] dmem [NUM_MEM_LOCS];

   logic [REG_WIDTH-1:0] pc;
   logic [31:0]          ir;
   logic [REG_WIDTH-1:0] a_reg;
   logic [REG_WIDTH-1:0] b_reg;
   logic [REG_WIDTH-1:0] imm_reg;
   logic [REG_WIDTH-1:0] alu_reg;
   logic [REG_WIDTH-1:0] mdr;
   logic                 illegal_q;

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [4:0] rd;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign funct7 = ir[31:25];

   // Instruction memory has no reset and accepts writes regardless of core
   // state. A same-cycle write to the fetched word is not seen by FETCH,
   // because FETCH samples the array before this update lands.
   always_ff @(posedge clk) begin
      if (imem_we) begin
         imem[imem_addr] <= imem_wdata;
      end
   end

   logic is_legal;
   logic is_ebreak;

   assign is_ebreak = (ir == INST_EBREAK);

   always_comb begin
      is_legal = 1'b0;
      case (opcode)
         OPC_OP: begin
            if (funct7 == 7'b0000000) begin
               is_legal = 1'b1;
            end else if (funct7 == 7'b0100000) begin
               is_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
            end
`ifdef RISCV_MUL_EN
            else if (funct7 == 7'b0000001) begin
               is_legal = (funct3 == 3'b000);
            end
`endif
         end
         OPC_OPIMM: begin
            case (funct3)
               3'b001:  is_legal = (funct7 == 7'b0000000);
               3'b101:  is_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
               3'b011:  is_legal = 1'b0;
               default: is_legal = 1'b1;
            endcase
         end
         OPC_LOAD,
         OPC_STORE:  is_legal = (funct3 == 3'b010);
         OPC_BRANCH: is_legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                                (funct3 == 3'b100) || (funct3 == 3'b101);
         OPC_JAL,
         OPC_LUI:    is_legal = 1'b1;
         default:    is_legal = 1'b0;
      endcase
   end

   logic [31:0]          imm32;
   logic [REG_WIDTH-1:0] imm_ext;

   always_comb begin
      case (opcode)
         OPC_STORE:  imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         OPC_BRANCH: imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         OPC_JAL:    imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         OPC_LUI:    imm32 = {ir[31:12], 12'b0};
         default:    imm32 = {{20{ir[31]}}, ir[31:20]};
      endcase
   end

   assign imm_ext = REG_WIDTH'($signed(imm32));

   // Indices past REG_COUNT read as zero.
   logic [REG_WIDTH-1:0] rs1_val;
   logic [REG_WIDTH-1:0] rs2_val;
   logic                 rd_ok;

   assign rs1_val = (32'(rs1) < REG_COUNT) ? rf[RIDX_W'(rs1)] : '0;
   assign rs2_val = (32'(rs2) < REG_COUNT) ? rf[RIDX_W'(rs2)] : '0;

   // Writes to x0 and to indices past REG_COUNT are dropped.
   assign rd_ok = (rd != 5'd0) && (32'(rd) < REG_COUNT);

   logic [REG_WIDTH-1:0] op_b;
   logic [SH_W-1:0]      shamt;
   logic [REG_WIDTH-1:0] alu_res;
   logic                 br_take;

   assign op_b  = (opcode == OPC_OP) ? b_reg : imm_reg;
   assign shamt = op_b[SH_W-1:0];

   always_comb begin
      alu_res = a_reg + imm_reg;    // effective address for LW/SW
      case (opcode)
         OPC_OP,
         OPC_OPIMM: begin
            case (funct3)
               // funct7[5] selects SUB only for register-register; in OP-IMM
               // that bit belongs to the immediate.
               3'b000:  alu_res = ((opcode == OPC_OP) && funct7[5]) ? a_reg - op_b
                                                                    : a_reg + op_b;
               3'b001:  alu_res = a_reg << shamt;
               3'b010:  alu_res = REG_WIDTH'($signed(a_reg) < $signed(op_b));
               3'b011:  alu_res = REG_WIDTH'(a_reg < op_b);
               3'b100:  alu_res = a_reg ^ op_b;
               3'b101:  alu_res = funct7[5] ? REG_WIDTH'($signed(a_reg) >>> shamt)
                                            : a_reg >> shamt;
               3'b110:  alu_res = a_reg | op_b;
               default: alu_res = a_reg & op_b;
            endcase
`ifdef RISCV_MUL_EN
            if ((opcode == OPC_OP) && (funct7 == 7'b0000001)) begin
               alu_res = a_reg * b_reg;
            end
`endif
         end
         OPC_JAL: alu_res = pc + REG_WIDTH'(4);
         OPC_LUI: alu_res = imm_reg;
         default: ;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  br_take = (a_reg == b_reg);
         3'b001:  br_take = (a_reg != b_reg);
         3'b100:  br_take = ($signed(a_reg) <  $signed(b_reg));
         3'b101:  br_take = ($signed(a_reg) >= $signed(b_reg));
         default: br_take = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:     state_nxt = DECODE;
         DECODE:    state_nxt = (is_ebreak || !is_legal) ? HALT : EXECUTE;
         EXECUTE: begin
            if (opcode == OPC_BRANCH) begin
               state_nxt = FETCH;
            end else if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
               state_nxt = MEM;
            end else begin
               state_nxt = WRITEBACK;
            end
         end
         MEM:       state_nxt = (opcode == OPC_LOAD) ? WRITEBACK : FETCH;
         WRITEBACK: state_nxt = FETCH;
         HALT:      state_nxt = HALT;
         default:   state_nxt = FETCH;
      endcase
   end

   logic [DADDR_W-1:0] daddr;

   assign daddr = alu_reg[DADDR_W+1:2];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc        <= '0;
         ir        <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         imm_reg   <= '0;
         alu_reg   <= '0;
         mdr       <= '0;
         illegal_q <= 1'b0;
         for (int i = 0; i < REG_COUNT; i++) begin
            rf[i] <= '0;
         end
         for (int i = 0; i < NUM_MEM_LOCS; i++) begin
            dmem[i] <= '0;
         end
      end else begin
         case (state)
            FETCH: ir <= imem[pc[IADDR_W+1:2]];
            DECODE: begin
               a_reg   <= rs1_val;
               b_reg   <= rs2_val;
               imm_reg <= imm_ext;
               if (!is_ebreak && !is_legal) begin
                  illegal_q <= 1'b1;
               end
            end
            EXECUTE: begin
               alu_reg <= alu_res;
               if (opcode == OPC_BRANCH) begin
                  pc <= br_take ? pc + imm_reg : pc + REG_WIDTH'(4);
               end
            end
            MEM: begin
               if (opcode == OPC_LOAD) begin
                  mdr <= dmem[daddr];
               end else begin
                  dmem[daddr] <= b_reg;
                  pc          <= pc + REG_WIDTH'(4);
               end
            end
            WRITEBACK: begin
               if (rd_ok) begin
                  rf[RIDX_W'(rd)] <= (opcode == OPC_LOAD) ? mdr : alu_reg;
               end
               pc <= (opcode == OPC_JAL) ? pc + imm_reg : pc + REG_WIDTH'(4);
            end
            default: ;
         endcase
      end
   end

   assign x5      = rf[5];
   assign x6      = rf[6];
   assign mem1    = dmem[1];
   assign halted  = (state == HALT);
   assign illegal = illegal_q;

endmodule

// File: tb/tb_riscv_multi_cycle_processor.sv
module tb_riscv_multi_cycle_processor;

   logic        clk = 1'b0;
   logic        rstn;
   logic        imem_we;
   logic [6:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [31:0] x5;
   logic [31:0] x6;
   logic [31:0] mem1;
   logic        halted;
   logic        illegal;

   int errors = 0;
   int checks = 0;

   logic [31:0] prog [$];

   always #5 clk = ~clk;

   riscv_multi_cycle_processor dut (
      .clk        (clk),
      .rstn       (rstn),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .x5         (x5),
      .x6         (x6),
      .mem1       (mem1),
      .halted     (halted),
      .illegal    (illegal)
   );

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   function automatic logic [31:0] enc_r(input int f7, input int r2, input int r1,
                                         input int f3, input int rd, input int opc);
      return {7'(f7), 5'(r2), 5'(r1), 3'(f3), 5'(rd), 7'(opc)};
   endfunction

   function automatic logic [31:0] enc_i(input int imm, input int r1, input int f3,
                                         input int rd);
      logic [11:0] i12;
      i12 = 12'(imm);
      return {i12, 5'(r1), 3'(f3), 5'(rd), 7'h13};
   endfunction

   function automatic logic [31:0] enc_lw(input int imm, input int r1, input int rd);
      logic [11:0] i12;
      i12 = 12'(imm);
      return {i12, 5'(r1), 3'b010, 5'(rd), 7'h03};
   endfunction

   function automatic logic [31:0] enc_sw(input int imm, input int r2, input int r1);
      logic [11:0] i12;
      i12 = 12'(imm);
      return {i12[11:5], 5'(r2), 5'(r1), 3'b010, i12[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input int off, input int r2, input int r1,
                                         input int f3);
      logic [12:0] i13;
      i13 = 13'(off);
      return {i13[12], i13[10:5], 5'(r2), 5'(r1), 3'(f3), i13[4:1], i13[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_jal(input int off, input int rd);
      logic [20:0] i21;
      i21 = 21'(off);
      return {i21[20], i21[10:1], i21[11], i21[19:12], 5'(rd), 7'h6F};
   endfunction

   function automatic logic [31:0] enc_lui(input int imm20, input int rd);
      return {20'(imm20), 5'(rd), 7'h37};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Holds reset, loads prog[] through the imem port, then releases reset
   // between edges, so the next rising edge is cycle 1 of the program.
   task automatic start_prog();
      rstn = 1'b0;
      foreach (prog[i]) begin
         imem_we    = 1'b1;
         imem_addr  = 7'(i);
         imem_wdata = prog[i];
         @(posedge clk);
         #1;
      end
      imem_we = 1'b0;
      rstn    = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      step(2);
      checks++; if (x5 !== 32'd0)   begin errors++; $display("FAIL reset_x5: got %h want %h", x5, 32'd0); end
      checks++; if (x6 !== 32'd0)   begin errors++; $display("FAIL reset_x6: got %h want %h", x6, 32'd0); end
      checks++; if (mem1 !== 32'd0) begin errors++; $display("FAIL reset_mem1: got %h want %h", mem1, 32'd0); end
      checks++; if (halted !== 1'b0)  begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
   endtask

   task automatic test_arith();
      prog = {enc_i(7, 0, 0, 5), enc_i(-3, 0, 0, 6), enc_r(0, 6, 5, 0, 5, 7'h33), EBREAK};
      start_prog();
      step(3);   // edge 3: first ADDI not yet written back
      checks++; if (x5 !== 32'd0) begin errors++; $display("FAIL arith_x5_early: got %h want %h", x5, 32'd0); end
      step(1);   // edge 4
      checks++; if (x5 !== 32'd7) begin errors++; $display("FAIL arith_x5_addi: got %h want %h", x5, 32'd7); end
      step(4);   // edge 8
      checks++; if (x6 !== 32'hFFFF_FFFD) begin errors++; $display("FAIL arith_x6_neg: got %h want %h", x6, 32'hFFFF_FFFD); end
      step(4);   // edge 12
      checks++; if (x5 !== 32'd4) begin errors++; $display("FAIL arith_x5_add: got %h want %h", x5, 32'd4); end
      step(1);   // edge 13: EBREAK only fetched
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL arith_halt_early: got %b want 0", halted); end
      step(2);   // edge 15
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL arith_halted: got %b want 1", halted); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL arith_illegal: got %b want 0", illegal); end
      step(10);
      checks++; if (x5 !== 32'd4 || halted !== 1'b1) begin errors++; $display("FAIL arith_frozen: got x5=%h halted=%b want x5=%h halted=1", x5, halted, 32'd4); end
   endtask

   task automatic test_load_store();
      prog = {enc_i(42, 0, 0, 5), enc_sw(4, 5, 0), enc_lw(4, 0, 6), EBREAK};
      start_prog();
      step(7);   // edge 7: SW in EXECUTE, memory untouched
      checks++; if (mem1 !== 32'd0) begin errors++; $display("FAIL ls_mem1_early: got %h want %h", mem1, 32'd0); end
      step(1);   // edge 8: SW MEM
      checks++; if (mem1 !== 32'd42) begin errors++; $display("FAIL ls_mem1_sw: got %h want %h", mem1, 32'd42); end
      step(4);   // edge 12: LW in MEM, no writeback yet
      checks++; if (x6 !== 32'd0) begin errors++; $display("FAIL ls_x6_early: got %h want %h", x6, 32'd0); end
      step(1);   // edge 13: LW writeback (5th cycle)
      checks++; if (x6 !== 32'd42) begin errors++; $display("FAIL ls_x6_lw: got %h want %h", x6, 32'd42); end
      step(3);   // edge 16
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ls_halted: got %b want 1", halted); end
   endtask

   task automatic test_branch_loop();
      prog = {enc_i(3, 0, 0, 6), enc_i(1, 5, 0, 5), enc_b(-4, 6, 5, 1), EBREAK};
      start_prog();
      step(8);   // first increment at edge 8
      checks++; if (x5 !== 32'd1) begin errors++; $display("FAIL loop_iter1: got %h want %h", x5, 32'd1); end
      step(7);   // BNE taken (3 cycles) then ADDI: edge 15
      checks++; if (x5 !== 32'd2) begin errors++; $display("FAIL loop_iter2: got %h want %h", x5, 32'd2); end
      step(7);   // edge 22
      checks++; if (x5 !== 32'd3) begin errors++; $display("FAIL loop_iter3: got %h want %h", x5, 32'd3); end
      step(4);   // edge 26: BNE fell through at 25, EBREAK fetched
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL loop_halt_early: got %b want 0", halted); end
      step(2);   // edge 28
      checks++; if (halted !== 1'b1 || x5 !== 32'd3 || x6 !== 32'd3) begin errors++; $display("FAIL loop_final: got halted=%b x5=%h x6=%h want 1 3 3", halted, x5, x6); end
   endtask

   task automatic test_wrap_x0();
      prog = {enc_i(99, 0, 0, 5), enc_sw(260, 5, 0), enc_i(1, 0, 0, 6),
              enc_i(5, 0, 0, 0), enc_r(0, 0, 0, 0, 6, 7'h33), EBREAK};
      start_prog();
      step(8);
      checks++; if (mem1 !== 32'd99) begin errors++; $display("FAIL wrap_mem1: got %h want %h", mem1, 32'd99); end
      step(4);
      checks++; if (x6 !== 32'd1) begin errors++; $display("FAIL wrap_x6_set: got %h want %h", x6, 32'd1); end
      step(8);   // ADD x6,x0,x0 after ADDI x0,x0,5
      checks++; if (x6 !== 32'd0) begin errors++; $display("FAIL x0_stays_zero: got %h want %h", x6, 32'd0); end
   endtask

   task automatic test_alu_ops();
      prog = {enc_lui(20'h80000, 5), enc_r(7'h20, 4, 5, 5, 6, 7'h13),
              enc_r(7'h20, 5, 6, 0, 6, 7'h33), enc_r(0, 6, 5, 2, 5, 7'h33),
              enc_jal(8, 6), enc_i(77, 0, 0, 5), EBREAK};
      start_prog();
      step(4);
      checks++; if (x5 !== 32'h8000_0000) begin errors++; $display("FAIL alu_lui: got %h want %h", x5, 32'h8000_0000); end
      step(4);
      checks++; if (x6 !== 32'hF800_0000) begin errors++; $display("FAIL alu_srai: got %h want %h", x6, 32'hF800_0000); end
      step(4);
      checks++; if (x6 !== 32'h7800_0000) begin errors++; $display("FAIL alu_sub: got %h want %h", x6, 32'h7800_0000); end
      step(4);
      checks++; if (x5 !== 32'd1) begin errors++; $display("FAIL alu_slt: got %h want %h", x5, 32'd1); end
      step(4);
      checks++; if (x6 !== 32'd20) begin errors++; $display("FAIL alu_jal_link: got %h want %h", x6, 32'd20); end
      step(3);   // edge 23: jumped over ADDI x5,77 to EBREAK
      checks++; if (halted !== 1'b1 || x5 !== 32'd1) begin errors++; $display("FAIL alu_jal_target: got halted=%b x5=%h want 1 %h", halted, x5, 32'd1); end
   endtask

   task automatic test_illegal();
      prog = {enc_i(9, 0, 0, 5), 32'h0000_007F, enc_i(1, 0, 0, 6), enc_sw(4, 5, 0)};
      start_prog();
      step(4);
      checks++; if (x5 !== 32'd9) begin errors++; $display("FAIL ill_x5_pre: got %h want %h", x5, 32'd9); end
      step(3);   // opcode 0x7F decoded at edge 6
      checks++; if (halted !== 1'b1 || illegal !== 1'b1) begin errors++; $display("FAIL ill_flags: got halted=%b illegal=%b want 1 1", halted, illegal); end
      step(20);
      checks++; if (x5 !== 32'd9 || x6 !== 32'd0 || mem1 !== 32'd0) begin errors++; $display("FAIL ill_no_writes: got x5=%h x6=%h mem1=%h want 9 0 0", x5, x6, mem1); end
   endtask

   task automatic test_mul();
      prog = {enc_i(6, 0, 0, 5), enc_i(7, 0, 0, 6), enc_r(1, 6, 5, 0, 5, 7'h33), EBREAK};
      start_prog();
      step(15);
`ifdef RISCV_MUL_EN
      checks++; if (x5 !== 32'd42) begin errors++; $display("FAIL mul_result: got %h want %h", x5, 32'd42); end
      checks++; if (halted !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL mul_flags: got halted=%b illegal=%b want 1 0", halted, illegal); end
`else
      checks++; if (x5 !== 32'd6 || x6 !== 32'd7) begin errors++; $display("FAIL mul_no_write: got x5=%h x6=%h want 6 7", x5, x6); end
      checks++; if (halted !== 1'b1 || illegal !== 1'b1) begin errors++; $display("FAIL mul_flags: got halted=%b illegal=%b want 1 1", halted, illegal); end
`endif
   endtask

   task automatic test_reset_mid_sw();
      prog = {enc_i(42, 0, 0, 5), enc_sw(4, 5, 0), EBREAK};
      start_prog();
      step(7);   // SW now in MEM
      rstn = 1'b0;
      #1;
      checks++; if (mem1 !== 32'd0 || x5 !== 32'd0) begin errors++; $display("FAIL rst_mid_clear: got mem1=%h x5=%h want 0 0", mem1, x5); end
      step(1);
      checks++; if (mem1 !== 32'd0) begin errors++; $display("FAIL rst_mid_no_sw: got %h want %h", mem1, 32'd0); end
      rstn = 1'b1;
      step(4);
      checks++; if (x5 !== 32'd42) begin errors++; $display("FAIL rst_restart_x5: got %h want %h", x5, 32'd42); end
      step(4);
      checks++; if (mem1 !== 32'd42) begin errors++; $display("FAIL rst_restart_sw: got %h want %h", mem1, 32'd42); end
   endtask

   initial begin
      rstn       = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = '0;
      imem_wdata = '0;
      test_reset();
      test_arith();
      test_load_store();
      test_branch_loop();
      test_wrap_x0();
      test_alu_ops();
      test_illegal();
      test_mul();
      test_reset_mid_sw();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/riscv_multi_cycle_processor.md
RISCV_MULTI_CYCLE_PROCESSOR -- requirements
Module: riscv_multi_cycle_processor

Interface
REQ-001 Parameter REG_WIDTH, default 32: datapath, register and data-memory word width.
REQ-002 Parameter REG_COUNT, default 32: architectural registers; x0 hardwired to zero.
REQ-003 Parameter NUM_MEM_LOCS, default 64: data-memory depth in words.
REQ-004 Parameter NUM_INST, default 128: instruction-memory depth in 32-bit words.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rstn, input, 1: reset, asynchronous and active-low.
REQ-007 Port imem_we, input, 1: instruction-memory write enable for program load.
REQ-008 Port imem_addr, input, $clog2(NUM_INST): instruction word index for the load.
REQ-009 Port imem_wdata, input, 32: instruction word to load.
REQ-010 Port x5, output, REG_WIDTH: live contents of register x5.
REQ-011 Port x6, output, REG_WIDTH: live contents of register x6.
REQ-012 Port mem1, output, REG_WIDTH: live contents of data-memory word 1.
REQ-013 Port halted, output, 1: core has stopped on EBREAK or an illegal instruction.
REQ-014 Port illegal, output, 1: the stop was caused by an unsupported encoding.

Function
REQ-015 FSM states: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT; one state per cycle.
REQ-016 FETCH latches imem[pc[..:2] mod NUM_INST] into the IR; pc low two bits ignored.
REQ-017 DECODE reads rs1/rs2 into A/B latches and forms the sign-extended immediate.
REQ-018 Supported: R-type ADD SUB AND OR XOR SLT SLTU SLL SRL SRA; I-type ADDI ANDI ORI XORI SLTI SLLI SRLI SRAI; LW, SW, BEQ, BNE, BLT, BGE, JAL, LUI, EBREAK.
REQ-019 Cycles per instruction: branch 3 (F,D,E); SW 4 (F,D,E,M); R/I/JAL/LUI 4 (F,D,E,W); LW 5 (F,D,E,M,W).
REQ-020 Branch taken: pc <= pc + B-immediate at end of EXECUTE; otherwise pc <= pc + 4.
REQ-021 JAL: rd <= pc + 4 and pc <= pc + J-immediate in WRITEBACK.
REQ-022 Data address = (rs1 + imm) >> 2, taken modulo NUM_MEM_LOCS (wrap-around, no fault).
REQ-023 Arithmetic wraps modulo 2^REG_WIDTH; shift amount uses the low $clog2(REG_WIDTH) bits.
REQ-024 Writes to x0 discarded; rd index >= REG_COUNT discarded.
REQ-025 EBREAK (0x00100073) in DECODE -> HALT; halted=1, pc frozen, no further state change.
REQ-026 Unsupported opcode/funct in DECODE -> HALT with illegal=1; no register or memory write.
REQ-027 HALT is left only by reset.
REQ-028 imem_we writes instruction memory on a rising edge in any state, including while rstn is low.
REQ-029 An imem write to the word being fetched in the same cycle: FETCH returns the old word.

Reset
REQ-030 rstn low: state=FETCH, pc=0, IR=0, all registers=0, data memory=0, halted=0, illegal=0.
REQ-031 Instruction memory is not cleared by reset.
REQ-032 Reset mid-instruction abandons it; no partial register or memory write completes.

Configuration
REQ-033 Macro RISCV_MUL_EN defined: MUL (funct7=0000001, funct3=000) supported, low REG_WIDTH bits of rs1*rs2, 4 cycles.
REQ-034 Macro RISCV_MUL_EN undefined: MUL encoding treated as illegal per REQ-026.

Verification
REQ-035 ADDI x5,x0,7; ADDI x6,x0,-3; ADD x5,x5,x6; EBREAK -> x5=4, x6=0xFFFFFFFD, halted=1 after 4+4+4+3 cycles.
REQ-036 ADDI x5,x0,42; SW x5,4(x0); LW x6,4(x0) -> mem1=42 after SW, x6=42; LW takes 5 cycles.
REQ-037 Loop ADDI x5,x5,1; BNE x5,x6 back, x6=3 -> x5=3, branch taken twice, fall through once.
REQ-038 SW to byte address 4*(NUM_MEM_LOCS+1) -> mem1 updated (wrap); ADDI x0,x0,5 -> x0 stays 0.
REQ-039 Opcode 0x7F in program -> halted=1, illegal=1, x5/x6/mem1 unchanged; MUL with RISCV_MUL_EN undefined does the same.
REQ-040 rstn pulsed low during MEM of SW -> mem1 stays 0, pc=0, program restarts from word 0.
